// File: rtl/alu_serial_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_serial_sequencer
// Purpose  : Multi-cycle front-end for an external 4-bit combinational
//            arithmetic stage. It performs 4*NIBBLES-bit arithmetic one
//            nibble per clock, using a registered carry chain, and returns
//            the wide result with carry and zero flags.
// Ports    : clk, rst_n          - clock, synchronous active-low reset
//            in_valid/in_ready   - operand handshake (in_a, in_b, in_op)
//            out_valid/out_ready - result handshake (out_result, out_carry,
//                                  out_zero)
//            AS_A/AS_B/AS_Ci/AS_S0/AS_S1 - drive to arithmetic stage
//            AS_AP/AS_Co         - sum nibble and carry from arithmetic stage
// Options  : ALU_SEQ_ZERO_FLAG_EN - when defined, out_zero is a registered
//            (result == 0) flag; otherwise out_zero is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module alu_serial_sequencer #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4*NIBBLES-1:0]   in_a,
  input  logic [4*NIBBLES-1:0]   in_b,
  input  logic [2:0]             in_op,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [4*NIBBLES-1:0]   out_result,
  output logic                   out_carry,
  output logic                   out_zero,
  output logic [3:0]             AS_A,
  output logic [3:0]             AS_B,
  output logic                   AS_Ci,
  output logic                   AS_S0,
  output logic                   AS_S1,
  input  logic [3:0]             AS_AP,
  input  logic                   AS_Co
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = $clog2(NIBBLES);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] idx;
  logic [W-1:0]     a_reg;
  logic [W-1:0]     b_reg;
  logic [2:0]       op_reg;
  logic             carry_reg;
  logic [W-1:0]     result;
  logic             carry_out_reg;

  logic [W-1:0]     next_result;
  logic [3:0]       nib_a;
  logic [3:0]       nib_b;
  logic             last_nibble;

  assign last_nibble = (idx == IDX_W'(NIBBLES - 1));

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: if (in_valid)    state_next = ST_RUN;
      ST_RUN:  if (last_nibble) state_next = ST_DONE;
      ST_DONE: if (out_ready)   state_next = ST_IDLE;
      default:                  state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Nibble selection and result merge: nibble idx of the operands goes to the
  // stage, and the returned sum nibble is merged into the partial result.
  // --------------------------------------------------------------------------
  always_comb begin
    next_result = result;
    nib_a       = 4'h0;
    nib_b       = 4'h0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx == IDX_W'(i)) begin
        next_result[i*4 +: 4] = AS_AP;
        nib_a                 = a_reg[i*4 +: 4];
        nib_b                 = b_reg[i*4 +: 4];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready  = (state == ST_IDLE);
    out_valid = (state == ST_DONE);
    AS_A      = 4'h0;
    AS_B      = 4'h0;
    AS_Ci     = 1'b0;
    AS_S0     = 1'b0;
    AS_S1     = 1'b0;
    if (state == ST_RUN) begin
      AS_A  = nib_a;
      AS_B  = nib_b;
      // The first nibble takes the op's carry-in; later nibbles take the
      // carry registered from the previous nibble.
      AS_Ci = (idx == '0) ? op_reg[0] : carry_reg;
      AS_S0 = op_reg[1];
      AS_S1 = op_reg[2];
    end
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx           <= '0;
      a_reg         <= '0;
      b_reg         <= '0;
      op_reg        <= 3'b000;
      carry_reg     <= 1'b0;
      result        <= '0;
      carry_out_reg <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            a_reg  <= in_a;
            b_reg  <= in_b;
            op_reg <= in_op;
            idx    <= '0;
            result <= '0;
          end
        end
        ST_RUN: begin
          result    <= next_result;
          carry_reg <= AS_Co;
          if (last_nibble) begin
            idx           <= '0;
            carry_out_reg <= AS_Co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign out_result = result;
  assign out_carry  = carry_out_reg;

`ifdef ALU_SEQ_ZERO_FLAG_EN
  logic zero_reg;

  // Evaluated on the merged result so the flag lands with the final nibble.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      zero_reg <= 1'b0;
    end else if ((state == ST_RUN) && last_nibble) begin
      zero_reg <= (next_result == '0);
    end
  end

  assign out_zero = zero_reg;
`else
  assign out_zero = 1'b0;
`endif

endmodule
`default_nettype wire
